fft_frame_feeder: RTL and testbench
===================================

// Module: fft_frame_feeder
// PURPOSE
//  Upstream-side companion of serial_fft. Accepts complex samples over a valid/ready stream and
//  buffers them in a FIFO. Issues them to serial_fft as back-to-back i_valid frames of size N.
//  Holds the FFT size steady for each frame and watches serial_fft o_valid to learn when the
//  core returns to LOAD, then releases the next frame.
// PARAMETERS
//  NBD      8   bits per real/imag sample
//  NSIZES   4   number of FFT sizes, matches serial_fft
//  MAXSIZE  16  max FFT size; N = MAXSIZE >> size
//  DEPTH    16  FIFO depth in samples; power of two, >= MAXSIZE
// PORTS
//  clk            in   1                Posedge clock.
//  rst_async_n    in   1                Asynchronous, active-low reset.
//  i_size         in   $clog2(NSIZES)   Requested size; sampled at frame start.
//  s_real         in   NBD              Upstream sample, real part.
//  s_imag         in   NBD              Upstream sample, imaginary part.
//  s_valid        in   1                Upstream sample valid.
//  s_ready        out  1                FIFO can accept; equals !full.
//  f_real         out  NBD              To serial_fft i_real; registered.
//  f_imag         out  NBD              To serial_fft i_imag; registered.
//  f_valid        out  1                To serial_fft i_valid; registered.
//  f_size         out  $clog2(NSIZES)   To serial_fft i_size; constant for the whole frame.
//  f_out_valid    in   1                From serial_fft o_valid.
//  o_busy         out  1                High while in FEED or WAIT.
//  o_frame_done   out  1                1-cycle pulse after the N-th f_out_valid.
//  o_err          out  1                Sticky: f_out_valid seen outside WAIT.
// BEHAVIOUR
//  Reset: FIFO empty; state IDLE; all outputs 0 (s_ready is 1 one cycle after release).
//  Handshake: push on s_valid&s_ready. Push while full is impossible (s_ready=0).
//   Push and pop in the same cycle are allowed when not full. s_ready is not raised by a same-cycle pop.
//  FSM IDLE -> FEED: when FIFO is non-empty.
//   - Latch f_size <= i_size and N.
//   - Feed count = 0.
//  FSM FEED: each cycle with FIFO non-empty:
//   - Pop one sample into f_real/f_imag; f_valid=1 on the next cycle.
//   - An empty FIFO gives f_valid=0 (gaps allowed; serial_fft only counts valid samples).
//   - After the N-th pop -> WAIT.
//  FSM WAIT: f_valid=0. Count f_out_valid pulses.
//   - On the N-th pulse: o_frame_done=1 next cycle, then -> IDLE.
//   - Upstream pushes continue during WAIT.
//  i_size changes are ignored outside IDLE->FEED. f_size holds through the last output.
//  Counters are $clog2(MAXSIZE)+1 bits wide, so count N=MAXSIZE exactly; wrap is never used.
//  f_out_valid in IDLE/FEED: sets o_err; does not change state.
//  Latency:
//   - First push into an idle block -> f_valid high 3 cycles later (push, IDLE->FEED, pop reg).
//   - Frame to frame: min 2 idle cycles after the last f_out_valid.
//  Reset mid-frame: FIFO and FSM clear immediately; partial frame is discarded.
//   The serial_fft shares the reset, so both restart in LOAD.
// CONFIGURATION
//  FEEDER_CONJ_EN defined:
//   - Adds input port i_inverse (1 bit), latched with i_size at frame start.
//   - When the latched value is 1, f_imag = -s_imag, so serial_fft computes the conj-IFFT pre-step.
//   - -2^(NBD-1) saturates to 2^(NBD-1)-1.
//  FEEDER_CONJ_EN undefined: no i_inverse port; f_imag = s_imag unchanged.
// TESTING
//  1. Reset, i_size=0. Push 16 samples (k,-k) back-to-back.
//     -> f_valid high 16 consecutive cycles, data in order, o_busy=1.
//     -> After 16 f_out_valid: o_frame_done pulse, o_busy=0.
//  2. i_size=2 (N=4). Push 8 samples.
//     -> 4 fed, then WAIT. Remaining 4 stay in the FIFO.
//     -> Fed only after 4 f_out_valid pulses + frame_done.
//  3. Fill the FIFO with 16 pushes during WAIT.
//     -> s_ready=0 at count 16. A 17th s_valid is held, not lost. s_ready returns after the first pop.
//  4. Change i_size 0->1 mid-FEED.
//     -> f_size stays 0 for the current frame. The next frame latches 1 (N=8).
//  5. Pulse f_out_valid in IDLE -> o_err=1, stays 1. Assert rst_async_n=0 mid-FEED -> all outputs 0, FIFO empty.
//  6. FEEDER_CONJ_EN, i_inverse=1. Push imag 5, -128.
//     -> f_imag = -5, 127.

Source files
------------

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: buffers a complex sample stream and releases it to serial_fft one N-sample frame at a time.
// Optional FEEDER_CONJ_EN adds i_inverse, which negates imag (saturating) for the conjugate-IFFT pre-step.
module fft_frame_feeder #(
  parameter int NBD     = 8,
  parameter int NSIZES  = 4,
  parameter int MAXSIZE = 16,
  parameter int DEPTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst_async_n,
  input  logic [$clog2(NSIZES)-1:0] i_size,
`ifdef FEEDER_CONJ_EN
  input  logic                      i_inverse,
`endif
  input  logic [NBD-1:0]            s_real,
  input  logic [NBD-1:0]            s_imag,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [NBD-1:0]            f_real,
  output logic [NBD-1:0]            f_imag,
  output logic                      f_valid,
  output logic [$clog2(NSIZES)-1:0] f_size,
  input  logic                      f_out_valid,
  output logic                      o_busy,
  output logic                      o_frame_done,
  output logic                      o_err
);
  localparam int SW = $clog2(NSIZES);
  localparam int CW = $clog2(MAXSIZE) + 1;
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, FEED, WAIT} state_t;
  state_t          state_q, state_d;
  logic [NBD-1:0]  mem_r [DEPTH];
  logic [NBD-1:0]  mem_i [DEPTH];
  logic [AW:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   n_q, n_d, cnt_q, cnt_d;
  logic [SW-1:0]   size_q, size_d;
  logic [NBD-1:0]  real_q, imag_q, imag_d, rd_imag;
  logic            ready_q, valid_q, done_q, done_d, err_q;
  logic            push, pop, empty, full_d;
  assign push    = s_valid & ready_q;
  assign empty   = wr_q == rd_q;
  assign wr_d    = wr_q + {{AW{1'b0}}, push};
  assign rd_d    = rd_q + {{AW{1'b0}}, pop};
  assign full_d  = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
  assign rd_imag = mem_i[rd_q[AW-1:0]];
`ifdef FEEDER_CONJ_EN
  logic inv_q, inv_d;
  assign inv_d  = (state_q == IDLE && !empty) ? i_inverse : inv_q;
  // The most negative value has no positive twin, so it clips to max.
  assign imag_d = !inv_q ? rd_imag :
                  (rd_imag == {1'b1, {(NBD-1){1'b0}}}) ? {1'b0, {(NBD-1){1'b1}}} : -rd_imag;
`else
  assign imag_d = rd_imag;
`endif
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (!empty) begin
        state_d = FEED;
        size_d  = i_size;
        n_d     = CW'(MAXSIZE) >> i_size;
        cnt_d   = '0;
      end
    end else if (state_q == FEED) begin
      pop = !empty;
      if (pop) begin
        cnt_d   = (cnt_q == n_q - 1'b1) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == n_q - 1'b1) ? WAIT : FEED;
      end
    end else if (f_out_valid) begin
      cnt_d   = cnt_q + 1'b1;
      done_d  = cnt_q == n_q - 1'b1;
      state_d = done_d ? IDLE : WAIT;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_q[AW-1:0]] <= s_real;
      mem_i[wr_q[AW-1:0]] <= s_imag;
    end
  end
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      real_q  <= '0;
      imag_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      ready_q <= !full_d;
      valid_q <= pop;
      done_q  <= done_d;
      err_q   <= err_q | (f_out_valid & (state_q != WAIT));
      if (pop) begin
        real_q <= mem_r[rd_q[AW-1:0]];
        imag_q <= imag_d;
      end
    end
  end
`ifdef FEEDER_CONJ_EN
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) inv_q <= 1'b0;
    else inv_q <= inv_d;
  end
`endif
  assign s_ready      = ready_q;
  assign f_real       = real_q;
  assign f_imag       = imag_q;
  assign f_valid      = valid_q;
  assign f_size       = size_q;
  assign o_busy       = state_q != IDLE;
  assign o_frame_done = done_q;
  assign o_err        = err_q;
endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb_fft_frame_feeder: directed stimulus, expected samples queued at push time and checked by a monitor.
module tb_fft_frame_feeder;
  logic       clk = 1'b0;
  logic       rst_async_n = 1'b0;
  logic [1:0] i_size, f_size;
  logic [7:0] s_real, s_imag, f_real, f_imag;
  logic       s_valid, s_ready, f_valid, f_out_valid, o_busy, o_frame_done, o_err;
`ifdef FEEDER_CONJ_EN
  logic       i_inverse;
`endif
  logic [17:0] sb[$];
  int checks = 0, passes = 0, fed = 0, run = 0, run_max = 0;
  always #5 clk = ~clk;
  fft_frame_feeder dut (
    .clk(clk), .rst_async_n(rst_async_n), .i_size(i_size),
`ifdef FEEDER_CONJ_EN
    .i_inverse(i_inverse),
`endif
    .s_real(s_real), .s_imag(s_imag), .s_valid(s_valid), .s_ready(s_ready),
    .f_real(f_real), .f_imag(f_imag), .f_valid(f_valid), .f_size(f_size),
    .f_out_valid(f_out_valid), .o_busy(o_busy), .o_frame_done(o_frame_done), .o_err(o_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  always @(negedge clk) begin
    if (rst_async_n) begin
      run = f_valid ? run + 1 : 0;
      if (run > run_max) run_max = run;
      if (f_valid) begin
        fed++;
        if (sb.size() == 0) chk("unexpected_valid", {31'd0, f_valid}, 32'd0);
        else chk("sample", {14'd0, f_real, f_imag, f_size}, {14'd0, sb.pop_front()});
      end
    end
  end
  task automatic push(input logic [7:0] r, input logic [7:0] i, input logic [7:0] ei, input logic [1:0] sz);
    int t = 0;
    s_real = r;
    s_imag = i;
    s_valid = 1'b1;
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) chk("push_timeout", {31'd0, s_ready}, 32'd1);
    else sb.push_back({r, ei, sz});
    @(negedge clk);
    s_valid = 1'b0;
  endtask
  task automatic wait_fed(input int target);
    int t = 0;
    while (fed < target && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("fed_reach", {31'd0, fed >= target}, 32'd1);
  endtask
  task automatic run_frame(input int n);
    for (int k = 0; k < n; k++) begin
      f_out_valid = 1'b1;
      @(negedge clk);
    end
    f_out_valid = 1'b0;
    chk("frame_done", {31'd0, o_frame_done}, 32'd1);
    chk("busy_after_frame", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    chk("done_pulse_width", {31'd0, o_frame_done}, 32'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    s_valid = 1'b0;
    f_out_valid = 1'b0;
    i_size = 2'd0;
    s_real = '0;
    s_imag = '0;
`ifdef FEEDER_CONJ_EN
    i_inverse = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_outputs", {9'd0, f_valid, s_ready, o_busy, o_err, o_frame_done, f_size, f_real, f_imag}, 32'd0);
    rst_async_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, s_ready}, 32'd1);
    // Full-size frame, back-to-back
    run_max = 0;
    for (int k = 0; k < 16; k++) push(8'(k), 8'(-k), 8'(-k), 2'd0);
    chk("busy_feed", {31'd0, o_busy}, 32'd1);
    wait_fed(16);
    chk("run_length", run_max, 32'd16);
    run_frame(16);
    // N=4 with 8 queued: second half must wait for the first frame's outputs
    i_size = 2'd2;
    for (int k = 0; k < 8; k++) push(8'(100 + k), 8'(k), 8'(k), 2'd2);
    wait_fed(20);
    repeat (8) @(negedge clk);
    chk("held_in_fifo", fed, 32'd20);
    chk("size_n4", {30'd0, f_size}, 32'd2);
    run_frame(4);
    wait_fed(24);
    run_frame(4);
    // Fill FIFO during WAIT, 17th push held
    for (int k = 0; k < 4; k++) push(8'(k), 8'(200 + k), 8'(200 + k), 2'd2);
    wait_fed(28);
    for (int k = 0; k < 16; k++) push(8'(16 + k), 8'(32 + k), 8'(32 + k), 2'd2);
    chk("ready_full", {31'd0, s_ready}, 32'd0);
    fork
      push(8'd99, 8'd98, 8'd98, 2'd2);
      begin
        repeat (3) @(negedge clk);
        chk("ready_held", {31'd0, s_ready}, 32'd0);
        chk("no_feed_in_wait", fed, 32'd28);
        run_frame(4);
      end
    join
    for (int k = 0; k < 3; k++) push(8'(120 + k), 8'(60 + k), 8'(60 + k), 2'd2);
    for (int f = 1; f <= 5; f++) begin
      wait_fed(28 + 4 * f);
      run_frame(4);
    end
    chk("fed_after_fill", fed, 32'd48);
    // i_size change mid-FEED only affects the next frame
    i_size = 2'd0;
    fork
      for (int k = 0; k < 16; k++) push(8'(3 * k), 8'(k + 7), 8'(k + 7), 2'd0);
      begin
        wait_fed(52);
        i_size = 2'd1;
      end
    join
    chk("size_mid_feed", {30'd0, f_size}, 32'd0);
    for (int k = 0; k < 8; k++) push(8'(180 + k), 8'(-k - 1), 8'(-k - 1), 2'd1);
    wait_fed(64);
    chk("size_in_wait", {30'd0, f_size}, 32'd0);
    run_frame(16);
    wait_fed(72);
    chk("size_next_frame", {30'd0, f_size}, 32'd1);
    run_frame(8);
    // Spurious f_out_valid in IDLE, then reset mid-FEED
    chk("err_clear", {31'd0, o_err}, 32'd0);
    f_out_valid = 1'b1;
    @(negedge clk);
    f_out_valid = 1'b0;
    chk("err_set", {31'd0, o_err}, 32'd1);
    chk("err_no_state_change", {31'd0, o_busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("err_sticky", {31'd0, o_err}, 32'd1);
    i_size = 2'd0;
    for (int k = 0; k < 16; k++) push(8'(k + 1), 8'(k + 2), 8'(k + 2), 2'd0);
    chk("busy_before_reset", {31'd0, o_busy}, 32'd1);
    rst_async_n = 1'b0;
    #1;
    sb.delete();
    chk("reset_mid_feed", {9'd0, f_valid, s_ready, o_busy, o_err, o_frame_done, f_size, f_real, f_imag}, 32'd0);
    repeat (2) @(negedge clk);
    rst_async_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst2", {31'd0, s_ready}, 32'd1);
    repeat (5) @(negedge clk);
    chk("fifo_cleared", {30'd0, o_busy, f_valid}, 32'd0);
`ifdef FEEDER_CONJ_EN
    begin
      int base;
      base = fed;
      i_inverse = 1'b1;
      push(8'd1, 8'd5, 8'hFB, 2'd0);
      push(8'd2, 8'h80, 8'h7F, 2'd0);
      push(8'd3, 8'd0, 8'd0, 2'd0);
      i_inverse = 1'b0;
      wait_fed(base + 3);
    end
`endif
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
